// File: rtl/sixteen_bit_sklansky_adder_pkg.sv
// Shared widths, the (g,p) pair type and index helpers for the 16-bit Sklansky adder.
// Pure declarations: no latency, no backpressure.
package sixteen_bit_sklansky_adder_pkg;

  localparam int ADDER_WIDTH   = 16;
  localparam int PREFIX_LEVELS = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // True when bit i takes part in a combine at level k rather than passing through.
  function automatic bit combines_at(input int i, input int k);
    return ((i >> k) & 1) == 1;
  endfunction

  // Lower-significance partner for bit i at level k: last bit of the preceding 2^k block.
  function automatic int prefix_src(input int i, input int k);
    return ((i >> k) << k) - 1;
  endfunction

endpackage

// File: rtl/sixteen_bit_sklansky_adder_prefix_cell.sv
// Sklansky (G,P) combine operator: merges a high group with the adjacent low group.
// Combinational, zero latency, no backpressure.
module sklansky_prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);

  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;

endmodule

// File: rtl/sixteen_bit_sklansky_adder.sv
// 16-bit unsigned adder built on a 4-level Sklansky prefix tree; {cout,sum} registered.
// Latency 1 cycle, one addition per cycle, no handshake and never stalls.
module sixteen_bit_sklansky_adder
  import sixteen_bit_sklansky_adder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDER_WIDTH-1:0] sum,
  output logic                   cout,
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b
);

  gp_t [ADDER_WIDTH-1:0] gp_bit;
  gp_t [ADDER_WIDTH-1:0] gp_fin;
  logic [ADDER_WIDTH-1:0] g_fin;
  logic [ADDER_WIDTH-1:0] p_fin;
  logic [ADDER_WIDTH-1:0] sum_nxt;
  logic                   cout_nxt;
  logic                   unused_fin_p;

  always_comb begin
    gp_bit = '0;
    for (int i = 0; i < ADDER_WIDTH; i++) begin
      gp_bit[i].g = a[i] & b[i];
      gp_bit[i].p = a[i] ^ b[i];
    end
  end

  for (genvar k = 0; k < PREFIX_LEVELS; k++) begin : lvl
    gp_t [ADDER_WIDTH-1:0] gp_in;
    gp_t [ADDER_WIDTH-1:0] gp_out;

    if (k == 0) begin : src_bits
      assign gp_in = gp_bit;
    end else begin : src_prev
      assign gp_in = lvl[k-1].gp_out;
    end

    for (genvar i = 0; i < ADDER_WIDTH; i++) begin : col
      if (combines_at(i, k)) begin : merge
        localparam int J = prefix_src(i, k);
        sklansky_prefix_cell u_cell (
          .g_hi  (gp_in[i].g),
          .p_hi  (gp_in[i].p),
          .g_lo  (gp_in[J].g),
          .p_lo  (gp_in[J].p),
          .g_out (gp_out[i].g),
          .p_out (gp_out[i].p)
        );
      end else begin : pass
        assign gp_out[i] = gp_in[i];
      end
    end
  end

  assign gp_fin = lvl[PREFIX_LEVELS-1].gp_out;

  // After the last level g_fin[i] is the carry out of bits i..0; group P is no longer needed.
  always_comb begin
    g_fin = '0;
    p_fin = '0;
    for (int i = 0; i < ADDER_WIDTH; i++) begin
      g_fin[i] = gp_fin[i].g;
      p_fin[i] = gp_fin[i].p;
    end
  end

  assign unused_fin_p = ^p_fin;

  always_comb begin
    sum_nxt    = '0;
    sum_nxt[0] = gp_bit[0].p;
    for (int i = 1; i < ADDER_WIDTH; i++) begin
      sum_nxt[i] = gp_bit[i].p ^ g_fin[i-1];
    end
    cout_nxt = g_fin[ADDER_WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_nxt;
      cout <= cout_nxt;
    end
  end

endmodule

// File: tb/tb_sixteen_bit_sklansky_adder.sv
// Directed and random checks of the registered Sklansky adder via an expected-result queue.
module tb_sixteen_bit_sklansky_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] sum;
  logic        cout;
  logic [15:0] a;
  logic [15:0] b;

  int tests;
  int fails;

  logic [16:0] exp_q [$];

  sixteen_bit_sklansky_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sum   (sum),
    .cout  (cout),
    .a     (a),
    .b     (b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive operands and queue the result expected one edge later.
  task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic [16:0] exp);
    a = va;
    b = vb;
    exp_q.push_back(exp);
  endtask

  // Advance one edge and compare the DUT against the oldest queued expectation.
  task automatic collect(input string tag);
    logic [16:0] exp;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed %h expected <queued result>", tag, {cout, sum});
    end else begin
      exp = exp_q.pop_front();
      check(tag, {cout, sum}, exp);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    tests = 0;
    fails = 0;

    rst_n = 1'b0;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    #2;
    check("reset_initial", {cout, sum}, 17'h0_0000);
    @(posedge clk);
    #1;
    check("reset_held_edge", {cout, sum}, 17'h0_0000);
    #3;
    rst_n = 1'b1;
    #1;
    check("reset_release_hold", {cout, sum}, 17'h0_0000);

    drive(16'hFFFF, 16'hFFFF, 17'h1_FFFE);
    collect("ffff_ffff");
    drive(16'h0000, 16'hFFFF, 17'h0_FFFF);
    collect("0000_ffff");
    drive(16'hAAAA, 16'h5555, 17'h0_FFFF);
    collect("aaaa_5555");
    drive(16'hCCCC, 16'hC006, 17'h1_8CD2);
    collect("cccc_c006");
    drive(16'hCCCC, 16'h0000, 17'h0_CCCC);
    collect("cccc_0000");
    drive(16'h8000, 16'h8000, 17'h1_0000);
    collect("8000_8000");
    drive(16'h0000, 16'h0007, 17'h0_0007);
    collect("0000_0007");

    // Mid-stream reset with a full-carry operand pair in flight.
    drive(16'hFFFF, 16'hFFFF, 17'h1_FFFE);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_async", {cout, sum}, 17'h0_0000);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midreset_discard", {cout, sum}, 17'h0_0000);
    #3;
    rst_n = 1'b1;
    #1;
    check("midreset_release_hold", {cout, sum}, 17'h0_0000);
    exp_q.push_back(17'h1_FFFE);
    collect("midreset_first_result");

    drive(16'h1234, 16'h4321, 17'h0_5555);
    collect("b2b_0");
    drive(16'h7FFF, 16'h0001, 17'h0_8000);
    collect("b2b_1");
    drive(16'hFFFF, 16'h0001, 17'h1_0000);
    collect("b2b_2");
    drive(16'h0001, 16'h0000, 17'h0_0001);
    collect("b2b_3");

    for (int n = 0; n < 10000; n++) begin
      ra = 16'($urandom());
      rb = 16'($urandom());
      drive(ra, rb, {1'b0, ra} + {1'b0, rb});
      collect("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sixteen_bit_sklansky_adder.md
SIXTEEN_BIT_SKLANSKY_ADDER -- requirements
Module: sixteen_bit_sklansky_adder

Interface
REQ-001 The block SHALL have no parameters; the operand width SHALL be fixed at 16 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port sum: output, 16 bits, registered sum bits [15:0].
REQ-006 Port cout: output, 1 bit, registered carry out of bit 15.
REQ-007 Port a: input, 16 bits, unsigned addend.
REQ-008 Port b: input, 16 bits, unsigned addend.
REQ-009 Non-clock positional port order SHALL be sum, cout, a, b, with clk and rst_n declared first.
REQ-010 There SHALL be no carry-in port; the implicit carry-in SHALL be 0.

Function
REQ-011 The block SHALL compute {cout, sum} = a + b as an unsigned 17-bit result, with no truncation other than sum being the low 16 bits.
REQ-012 The bitwise terms SHALL be g[i] = a[i] & b[i] and p[i] = a[i] ^ b[i] for i = 0..15.
REQ-013 The group (G,P) pairs SHALL use a Sklansky parallel-prefix tree with 4 levels, k = 0..3.
REQ-014 At level k, each bit i with bit k of i set SHALL combine with index j = ((i >> k) << k) - 1.
REQ-015 The level-k combine SHALL be G = G_i | (P_i & G_j) and P = P_i & P_j.
REQ-016 At level k, bits with bit k of i clear SHALL pass their (G,P) pair unchanged.
REQ-017 After level 3, G[i] SHALL equal the carry out of bits i..0.
REQ-018 The sum bits SHALL be sum[0] = p[0] and sum[i] = p[i] ^ G[i-1] for i = 1..15.
REQ-019 The carry out SHALL be cout = G[15].
REQ-020 The prefix tree SHALL be combinational, and sum and cout SHALL be captured in registers on each rising clk edge.
REQ-021 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on sum/cout after edge N.
REQ-022 Throughput SHALL be one addition per cycle, with no handshake and no stall.
REQ-023 Overflow SHALL wrap: FFFF+FFFF gives sum FFFE with cout 1; cout is the only overflow indication.
REQ-024 An addend of zero SHALL yield the other addend unchanged with cout 0.

Reset
REQ-025 While rst_n is low, sum SHALL be 16'h0000 and cout SHALL be 0, asynchronously and without waiting for clk.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-027 The first valid result SHALL appear after the first rising clk edge with rst_n high.
REQ-028 Reset deassertion SHALL be glitch-free with respect to outputs: they hold 0 until the next rising edge.

Structure
REQ-029 A shared package SHALL hold ADDER_WIDTH = 16 and PREFIX_LEVELS = 4, plus a packed gp_t typedef holding g and p bits.
REQ-030 The combine operator SHALL be one sub-module, sklansky_prefix_cell, with inputs (g_hi, p_hi, g_lo, p_lo) and outputs (g_out, p_out).
REQ-031 sklansky_prefix_cell SHALL be instantiated via generate loops per level and bit.
REQ-032 The top level SHALL contain only the bitwise g/p logic, the tree, the sum XORs and the output registers.
REQ-033 Behavioural "+" SHALL NOT be used for the datapath.

Verification
REQ-034 Apply a=FFFF, b=FFFF -> one cycle later sum=FFFE, cout=1.
REQ-035 Apply a=0000, b=FFFF, then a=AAAA, b=5555 -> each gives sum=FFFF, cout=0, showing full carry-propagate with no generate.
REQ-036 Apply a=CCCC, b=C006 -> sum=8CD2, cout=1; then a=CCCC, b=0000 -> sum=CCCC, cout=0.
REQ-037 Apply a=8000, b=8000 -> sum=0000, cout=1; then a=0000, b=0007 -> sum=0007, cout=0.
REQ-038 Assert rst_n low mid-stream with a=FFFF, b=FFFF applied -> sum=0000, cout=0 immediately; after release, the correct result appears on the next edge.
REQ-039 Apply back-to-back vectors on consecutive cycles plus 10,000 random pairs -> every {cout,sum} matches a+b exactly 1 cycle later.
